// File: rtl/blit_arb_pkg.sv
// Shared types and constants for the blitter memory-cycle arbiter.
package blit_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        REQ_PAR = 2'd0,
        REQ_SRC = 2'd1,
        REQ_DST = 2'd2,
        REQ_DWR = 2'd3
    } req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSWAIT = 2'd1,
        ST_RUN     = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/blit_cycle_arb_if.sv
// Request/bus bundle between the blitter requesters and the cycle arbiter.
interface blit_cycle_arb_if #(parameter int WS_W = 3);
    import blit_arb_pkg::*;

    logic               PARCRQ;
    logic               SRCCRQ;
    logic               DSTCRQ;
    logic               DWRCRQ;
    logic               BUSACK;
    logic               HOLD;
    logic [WS_W-1:0]    WAITS;
    logic               BUSRQ;
    logic               MEMRQ;
    logic [NUM_REQ-1:0] GNT;
    logic [1:0]         CYCSEL;
    logic               ICYCEND;
    logic               CYCEND;

    modport master (
        output PARCRQ, SRCCRQ, DSTCRQ, DWRCRQ, BUSACK, HOLD, WAITS,
        input  BUSRQ, MEMRQ, GNT, CYCSEL, ICYCEND, CYCEND
    );

    modport slave (
        input  PARCRQ, SRCCRQ, DSTCRQ, DWRCRQ, BUSACK, HOLD, WAITS,
        output BUSRQ, MEMRQ, GNT, CYCSEL, ICYCEND, CYCEND
    );

endinterface

// File: rtl/blit_cyc_timer.sv
// Loadable down-counter timing one memory cycle; emits MEMRQ and the end strobes.
module blit_cyc_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             memrq,
    output logic             icycend,
    output logic             cycend
);

    // remaining counts clocks still to run after the current one
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            memrq     <= 1'b0;
            icycend   <= 1'b0;
            cycend    <= 1'b0;
        end else if (load) begin
            remaining <= len - CNT_W'(1);
            memrq     <= 1'b1;
            icycend   <= (len == CNT_W'(2));
            cycend    <= 1'b0;
        end else if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
            memrq     <= 1'b1;
            icycend   <= (remaining == CNT_W'(2));
            cycend    <= (remaining == CNT_W'(1));
        end else begin
            memrq     <= 1'b0;
            icycend   <= 1'b0;
            cycend    <= 1'b0;
        end
    end

endmodule

// File: rtl/blit_cycle_arb.sv
// Blitter memory-cycle arbiter: acquires the bus and sequences requester cycles.
// Define BLIT_ARB_RR_EN for round-robin among SRC/DST/DWR (default: PAR>DWR>DST>SRC).
module blit_cycle_arb
    import blit_arb_pkg::*;
#(
    parameter int CYC_LEN = 2,
    parameter int WS_W    = 3
) (
    input  logic             CCLK,
    input  logic             RESETL,
    blit_cycle_arb_if.slave  bus
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] BUSWAIT = ST_BUSWAIT;
    localparam logic [1:0] RUN     = ST_RUN;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] req_vec;
    logic               req_any;
    logic [1:0]         next_sel;
    logic               start;
    logic [WS_W:0]      cyc_n;

    assign req_vec = {bus.DWRCRQ, bus.DSTCRQ, bus.SRCCRQ, bus.PARCRQ} & {NUM_REQ{~bus.HOLD}};
    assign req_any = |req_vec;
    assign cyc_n   = (WS_W+1)'(CYC_LEN) + {1'b0, bus.WAITS};
    assign start   = req_any && bus.BUSACK &&
                     ((state == BUSWAIT) || ((state == RUN) && bus.CYCEND));

`ifdef BLIT_ARB_RR_EN
    logic [1:0] rr_last;
    logic       found;
    int         cand;

    // Search SRC/DST/DWR starting just after the last one served
    always_comb begin
        next_sel = REQ_PAR;
        found    = req_vec[REQ_PAR];
        cand     = 0;
        for (int k = 0; k < 3; k++) begin
            cand = ((int'(rr_last) + k) % 3) + 1;
            if (!found && req_vec[cand[1:0]]) begin
                next_sel = cand[1:0];
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge CCLK or negedge RESETL) begin
        if (!RESETL)
            rr_last <= REQ_DWR;
        else if (start && (next_sel != REQ_PAR))
            rr_last <= next_sel;
    end
`else
    always_comb begin
        next_sel = REQ_PAR;
        if (req_vec[REQ_PAR])
            next_sel = REQ_PAR;
        else if (req_vec[REQ_DWR])
            next_sel = REQ_DWR;
        else if (req_vec[REQ_DST])
            next_sel = REQ_DST;
        else if (req_vec[REQ_SRC])
            next_sel = REQ_SRC;
    end
`endif

    // Decisions in RUN are taken only on the CYCEND clock so a cycle always completes
    always_ff @(posedge CCLK or negedge RESETL) begin
        if (!RESETL) begin
            state      <= IDLE;
            bus.BUSRQ  <= 1'b0;
            bus.GNT    <= '0;
            bus.CYCSEL <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state     <= BUSWAIT;
                        bus.BUSRQ <= 1'b1;
                    end
                end
                BUSWAIT: begin
                    if (!req_any) begin
                        state     <= IDLE;
                        bus.BUSRQ <= 1'b0;
                    end else if (bus.BUSACK) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.CYCEND) begin
                        if (!req_any) begin
                            state     <= IDLE;
                            bus.BUSRQ <= 1'b0;
                        end else if (!bus.BUSACK) begin
                            state <= BUSWAIT;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.BUSRQ <= 1'b0;
                end
            endcase
            if (start) begin
                bus.GNT    <= idx_to_onehot(next_sel);
                bus.CYCSEL <= next_sel;
            end
        end
    end

    blit_cyc_timer #(.CNT_W(WS_W+1)) u_timer (
        .clk     (CCLK),
        .rst_n   (RESETL),
        .load    (start),
        .len     (cyc_n),
        .memrq   (bus.MEMRQ),
        .icycend (bus.ICYCEND),
        .cycend  (bus.CYCEND)
    );

endmodule

// File: tb/tb_blit_cycle_arb.sv
// Bench for blit_cycle_arb: directed scenarios plus random traffic against a cycle-level model.
module tb_blit_cycle_arb;

    localparam int CYC_LEN = 2;
    localparam int WS_W    = 3;

    logic CCLK   = 1'b0;
    logic RESETL = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    blit_cycle_arb_if #(.WS_W(WS_W)) bus ();

    blit_cycle_arb #(.CYC_LEN(CYC_LEN), .WS_W(WS_W)) dut (
        .CCLK   (CCLK),
        .RESETL (RESETL),
        .bus    (bus)
    );

    always #5 CCLK = ~CCLK;

    // Reference: m_st 0 idle, 1 waiting for bus, 2 inside a cycle at clock m_pos of m_len
    int m_st    = 0;
    int m_pos   = 0;
    int m_len   = 0;
    int m_owner = 0;
    int m_last  = 3;
    bit m_busrq = 1'b0;

    function automatic int pick(input bit [3:0] r, input int last);
        int order[3];
        if (r[0]) return 0;
`ifdef BLIT_ARB_RR_EN
        for (int k = 0; k < 3; k++) order[k] = ((last + k) % 3) + 1;
`else
        order = '{3, 2, 1};
`endif
        for (int k = 0; k < 3; k++)
            if (r[order[k]]) return order[k];
        return 0;
    endfunction

    always @(posedge CCLK or negedge RESETL) begin : model_step
        bit [3:0] r;
        bit       decide;
        int       who;
        if (!RESETL) begin
            m_st    <= 0;
            m_pos   <= 0;
            m_len   <= 0;
            m_owner <= 0;
            m_last  <= 3;
            m_busrq <= 1'b0;
        end else begin
            r      = {bus.DWRCRQ, bus.DSTCRQ, bus.SRCCRQ, bus.PARCRQ} & {4{~bus.HOLD}};
            decide = (m_st == 1) || (m_st == 2 && m_pos == m_len);
            if (m_st == 0) begin
                if (r != 0) begin
                    m_st    <= 1;
                    m_busrq <= 1'b1;
                end
            end else if (decide) begin
                if (r == 0) begin
                    m_st    <= 0;
                    m_pos   <= 0;
                    m_busrq <= 1'b0;
                end else if (bus.BUSACK) begin
                    who     = pick(r, m_last);
                    m_owner <= who;
                    m_len   <= CYC_LEN + int'(bus.WAITS);
                    m_pos   <= 1;
                    m_st    <= 2;
                    if (who != 0) m_last <= who;
                end else begin
                    m_st  <= 1;
                    m_pos <= 0;
                end
            end else if (m_st == 2) begin
                m_pos <= m_pos + 1;
            end
        end
    end

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic set_reqs(input bit p, input bit s, input bit d, input bit w);
        bus.PARCRQ = p;
        bus.SRCCRQ = s;
        bus.DSTCRQ = d;
        bus.DWRCRQ = w;
    endtask

    task automatic test_reset();
        set_reqs(0, 0, 0, 0);
        bus.BUSACK = 1'b1;
        bus.HOLD   = 1'b0;
        bus.WAITS  = '0;
        #3;
        RESETL = 1'b0;
        #1;
        n_checks++;
        if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes got %b want 0000", {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND});
        end
        n_checks++;
        if ({bus.GNT, bus.CYCSEL} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_owner got %b want 000000", {bus.GNT, bus.CYCSEL});
        end
        tick();
        tick();
        RESETL = 1'b1;
        tick();
        n_checks++;
        if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_idle got %b want 0000", {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND});
        end
    endtask

    task automatic test_priority();
        logic [3:0] tbl_g [5];
        logic [1:0] tbl_s [5];
        int         idx;
`ifdef BLIT_ARB_RR_EN
        tbl_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
        tbl_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
`else
        tbl_g = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        tbl_s = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        RESETL = 1'b0;
        tick();
        RESETL = 1'b1;
        bus.WAITS = '0;
        tick();
        set_reqs(1, 1, 1, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k >= 2 && k <= 10 && (k % 2) == 0) begin
                idx = (k / 2) - 1;
                n_checks++;
                if ({bus.MEMRQ, bus.ICYCEND, bus.GNT, bus.CYCSEL} !== {2'b11, tbl_g[idx], tbl_s[idx]}) begin
                    n_fail++;
                    $display("[TB] FAIL priority_grant%0d got %b want %b", idx,
                             {bus.MEMRQ, bus.ICYCEND, bus.GNT, bus.CYCSEL}, {2'b11, tbl_g[idx], tbl_s[idx]});
                end
            end
            if (k == 2) bus.PARCRQ = 1'b0;
            if (k == 10) set_reqs(0, 0, 0, 0);
        end
        n_checks++;
        if ({bus.BUSRQ, bus.MEMRQ} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL priority_end got %b want 00", {bus.BUSRQ, bus.MEMRQ});
        end
    endtask

    task automatic test_single_par();
        logic [3:0] exp_s;
        int         n_icy = 0;
        int         n_cyc = 0;
        bit         in_cyc;
        bus.WAITS = '0;
        tick();
        bus.PARCRQ = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_cyc = (k >= 2 && k <= 7);
            exp_s  = {k <= 7, in_cyc, in_cyc && (k % 2) == 0, in_cyc && (k % 2) == 1};
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL single_par k=%0d got %b want %b", k,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND}, exp_s);
            end
            if (in_cyc) begin
                n_checks++;
                if (bus.GNT !== 4'b0001) begin
                    n_fail++;
                    $display("[TB] FAIL single_par_gnt k=%0d got %b want 0001", k, bus.GNT);
                end
            end
            n_icy += int'(bus.ICYCEND);
            n_cyc += int'(bus.CYCEND);
            if (k == 6) bus.PARCRQ = 1'b0;
        end
        n_checks++;
        if (n_icy != 3 || n_cyc != 3) begin
            n_fail++;
            $display("[TB] FAIL single_par_pairs got %0d/%0d want 3/3", n_icy, n_cyc);
        end
    endtask

    task automatic test_wait_states();
        logic [3:0] exp_s;
        bus.WAITS = 3'd3;
        tick();
        bus.SRCCRQ = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_s = {k <= 6, k >= 2 && k <= 6, k == 5, k == 6};
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL wait_states k=%0d got %b want %b", k,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND}, exp_s);
            end
            if (exp_s[2]) begin
                n_checks++;
                if ({bus.GNT, bus.CYCSEL} !== {4'b0010, 2'd1}) begin
                    n_fail++;
                    $display("[TB] FAIL wait_states_owner got %b want 001001", {bus.GNT, bus.CYCSEL});
                end
            end
            if (k == 2) bus.SRCCRQ = 1'b0;
            if (k == 3) bus.WAITS = '0;
        end
    endtask

    task automatic test_bus_loss();
        logic [3:0] exp_s;
        bus.WAITS  = 3'd2;
        bus.BUSACK = 1'b1;
        tick();
        bus.SRCCRQ = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_s = {k <= 12, (k >= 2 && k <= 5) || (k >= 9 && k <= 12), k == 4 || k == 11, k == 5 || k == 12};
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL bus_loss k=%0d got %b want %b", k,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND}, exp_s);
            end
            if (k == 3) bus.BUSACK = 1'b0;
            if (k == 8) bus.BUSACK = 1'b1;
            if (k == 9) bus.SRCCRQ = 1'b0;
        end
        bus.WAITS = '0;
    endtask

    task automatic test_hold();
        logic [3:0] exp_s;
        bus.WAITS = '0;
        tick();
        bus.DSTCRQ = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_s = {(k <= 3) || (k >= 8 && k <= 10), k == 2 || k == 3 || k == 9 || k == 10,
                     k == 2 || k == 9, k == 3 || k == 10};
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL hold k=%0d got %b want %b", k,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND}, exp_s);
            end
            if (exp_s[2]) begin
                n_checks++;
                if (bus.GNT !== 4'b0100) begin
                    n_fail++;
                    $display("[TB] FAIL hold_gnt k=%0d got %b want 0100", k, bus.GNT);
                end
            end
            if (k == 2) bus.HOLD = 1'b1;
            if (k == 7) bus.HOLD = 1'b0;
            if (k == 9) bus.DSTCRQ = 1'b0;
        end
    endtask

    task automatic test_reset_mid_cycle();
        logic [3:0] exp_s;
        bus.WAITS = 3'd2;
        tick();
        bus.PARCRQ = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if ({bus.MEMRQ, bus.CYCEND} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_pre got %b want 10", {bus.MEMRQ, bus.CYCEND});
        end
        RESETL = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND, bus.GNT, bus.CYCSEL} !== 10'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_abort j=%0d got %b want 0", j,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND, bus.GNT, bus.CYCSEL});
            end
            tick();
        end
        RESETL = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            exp_s = {j <= 5, j >= 2 && j <= 5, j == 4, j == 5};
            n_checks++;
            if ({bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND} !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_restart j=%0d got %b want %b", j,
                         {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND}, exp_s);
            end
            if (j == 2) bus.PARCRQ = 1'b0;
        end
        bus.WAITS = '0;
    endtask

    task automatic test_random();
        logic [9:0] obs;
        logic [9:0] exp_v;
        bit         run;
        for (int c = 0; c < 600; c++) begin
            tick();
            run   = (m_st == 2);
            obs   = {bus.BUSRQ, bus.MEMRQ, bus.ICYCEND, bus.CYCEND,
                     bus.MEMRQ ? bus.GNT : 4'b0, bus.MEMRQ ? bus.CYCSEL : 2'b0};
            exp_v = {m_busrq, run, run && (m_pos == m_len - 1), run && (m_pos == m_len),
                     run ? 4'(1 << m_owner) : 4'b0, run ? 2'(m_owner) : 2'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL random c=%0d got %b want %b", c, obs, exp_v);
            end
            set_reqs(($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0);
            bus.BUSACK = ($urandom % 4) != 0;
            bus.HOLD   = ($urandom % 8) == 0;
            bus.WAITS  = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_single_par();
        test_wait_states();
        test_bus_loss();
        test_hold();
        test_reset_mid_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
